// File: rtl/rr_req_pkg.sv
// Shared types and defaults for the round-robin requester: per-client state
// encoding, default sizing, and the wait-counter width helper.
package rr_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OWN  = 2'd2
    } state_e;

    localparam int DEF_N       = 3;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_TIMEOUT = 16;

    // Wide enough to hold TIMEOUT itself so the counter can saturate there.
    function automatic int wait_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_WAIT_W = wait_width(DEF_TIMEOUT);

endpackage

// File: rtl/rr_req_channel.sv
// One requester client: accepts a job, requests until granted, holds the
// request for the whole burst, and tracks starvation and spurious grants.
module rr_req_channel
    import rr_req_pkg::*;
#(
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_job_valid,
    input  logic [LEN_W-1:0] i_job_len,
    output logic             o_job_ready,
    output logic             o_go,
    input  logic             i_get,
    output logic             o_beat,
    output logic             o_done,
    output logic             o_starve,
    output logic             o_spurious
);

    localparam int                WAIT_W   = wait_width(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_e             r_state;
    logic [LEN_W-1:0]   r_rem;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_go;
    logic               r_done;
    logic               r_starve;
    logic               r_spurious;

    logic w_beat;

    assign w_beat      = (r_state == ST_OWN) && i_get;
    assign o_job_ready = (r_state == ST_IDLE);
    assign o_beat      = w_beat;
    assign o_go        = r_go;
    assign o_done      = r_done;
    assign o_starve    = r_starve;
    assign o_spurious  = r_spurious;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_wait     <= '0;
            r_go       <= 1'b0;
            r_done     <= 1'b0;
            r_starve   <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Checked against the registered request so a grant can never
            // open a burst by itself.
            if (i_get && !r_go) begin
                r_spurious <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_job_valid) begin
                        r_rem   <= i_job_len;
                        r_wait  <= '0;
                        r_go    <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_get) begin
                        r_state <= ST_OWN;
                    end else begin
                        if (r_wait != WAIT_MAX) begin
                            r_wait <= r_wait + 1'b1;
                        end
                        // Starvation is only reported; the request keeps waiting.
                        if (r_wait == WAIT_MAX - 1'b1) begin
                            r_starve <= 1'b1;
                        end
                    end
                end
                ST_OWN: begin
                    if (w_beat) begin
                        if (r_rem == '0) begin
                            r_go    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_rem <= r_rem - 1'b1;
                        end
                    end
                end
                default: begin
                    r_go    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/rr_client_requester.sv
// Requester side of the round-robin arbiter handshake: N independent client
// channels driving go[] and consuming get[].
module rr_client_requester
    import rr_req_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       i_job_valid,
    input  logic [N*LEN_W-1:0] i_job_len,
    output logic [N-1:0]       o_job_ready,
    output logic [N-1:0]       o_go,
    input  logic [N-1:0]       i_get,
    output logic [N-1:0]       o_beat,
    output logic [N-1:0]       o_done,
    output logic [N-1:0]       o_starve,
    output logic [N-1:0]       o_spurious
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            rr_req_channel #(
                .LEN_W   (LEN_W),
                .TIMEOUT (TIMEOUT)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_job_valid (i_job_valid[gi]),
                .i_job_len   (i_job_len[gi*LEN_W +: LEN_W]),
                .o_job_ready (o_job_ready[gi]),
                .o_go        (o_go[gi]),
                .i_get       (i_get[gi]),
                .o_beat      (o_beat[gi]),
                .o_done      (o_done[gi]),
                .o_starve    (o_starve[gi]),
                .o_spurious  (o_spurious[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_rr_client_requester.sv
// Self-checking bench for rr_client_requester: directed handshake scenarios
// plus a closed loop against a small round-robin arbiter model.
module tb_rr_client_requester;

    localparam int N     = 3;
    localparam int LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     tb_valid;
    logic [N*LEN_W-1:0] tb_len;
    logic [N-1:0]     tb_get;
    logic             arb_mode;
    logic [N-1:0]     w_get;
    logic [N-1:0]     o_job_ready, o_go, o_beat, o_done, o_starve, o_spurious;

    logic             arb_valid;
    logic [1:0]       arb_owner;
    logic [N-1:0]     arb_get;

    int n_compared;
    int n_mismatched;
    int unsigned exp_q[N][$];
    int beat_cnt[N];
    int done_cnt[N];
    int jobs_left[N];

    rr_client_requester #(.N(N), .LEN_W(LEN_W), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_job_valid (tb_valid),
        .i_job_len   (tb_len),
        .o_job_ready (o_job_ready),
        .o_go        (o_go),
        .i_get       (w_get),
        .o_beat      (o_beat),
        .o_done      (o_done),
        .o_starve    (o_starve),
        .o_spurious  (o_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter model: keeps the grant while the owner requests, then rotates.
    function automatic logic [2:0] arb_pick(input logic [N-1:0] go, input logic [1:0] last);
        logic [2:0] r;
        int idx;
        r = 3'b000;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!r[2] && go[idx]) r = {1'b1, 2'(idx)};
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_valid <= 1'b0;
            arb_owner <= 2'd0;
        end else if (!(arb_valid && o_go[arb_owner])) begin
            {arb_valid, arb_owner} <= arb_pick(o_go, arb_owner);
        end
    end

    assign arb_get = (arb_valid && o_go[arb_owner]) ? (N'(1) << arb_owner) : '0;
    assign w_get   = arb_mode ? arb_get : tb_get;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: count beats per client, compare against the queued burst
    // length whenever a done pulse appears.
    task automatic sb_sample();
        int unsigned e;
        if (!rst_n) return;
        for (int i = 0; i < N; i++) begin
            if (o_beat[i]) beat_cnt[i]++;
            if (o_done[i]) begin
                if (exp_q[i].size() == 0) begin
                    check_eq($sformatf("done_unexpected[%0d]", i), 32'd1, 32'd0);
                end else begin
                    e = exp_q[i].pop_front();
                    check_eq($sformatf("burst_beats[%0d]", i), beat_cnt[i], e);
                    $display("burst client=%0d beats=%0d expected=%0d", i, beat_cnt[i], e);
                    done_cnt[i]++;
                end
                beat_cnt[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [5:0] pat;
        logic any_left;
        n_compared = 0;
        n_mismatched = 0;
        for (int i = 0; i < N; i++) begin
            beat_cnt[i] = 0;
            done_cnt[i] = 0;
            jobs_left[i] = 0;
        end
        rst_n = 1'b0;
        tb_valid = '0;
        tb_len = '0;
        tb_get = '0;
        arb_mode = 1'b0;

        #3;
        check_eq("rst_go", o_go, 0);
        check_eq("rst_ready", o_job_ready, 3'b111);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_starve", o_starve, 0);
        check_eq("rst_spurious", o_spurious, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        check_eq("idle_go", o_go, 0);
        check_eq("idle_ready", o_job_ready, 3'b111);
        check_eq("idle_flags", {o_done, o_starve, o_spurious}, 0);

        // Single job on client 0, grant held from the cycle go rises.
        tb_len[3:0] = 4'd2;
        tb_valid[0] = 1'b1;
        check_eq("c0_ready", o_job_ready[0], 1);
        exp_q[0].push_back(3);
        tick();
        tb_valid[0] = 1'b0;
        check_eq("c0_go_rise", o_go[0], 1);
        tb_get[0] = 1'b1;
        n = 0;
        while (n < 20 && !o_done[0]) begin
            tick();
            n++;
        end
        tb_get[0] = 1'b0;
        check_eq("c0_done_seen", o_done[0], 1);
        check_eq("c0_latency", n, 4);
        check_eq("c0_go_fall", o_go[0], 0);
        tick();
        check_eq("c0_done_pulse", o_done[0], 0);
        check_eq("c0_spurious", o_spurious[0], 0);

        // Stalled burst on client 1.
        tb_len[7:4] = 4'd3;
        tb_valid[1] = 1'b1;
        exp_q[1].push_back(4);
        tick();
        tb_valid[1] = 1'b0;
        pat = 6'b101101;
        for (int p = 0; p < 6; p++) begin
            tb_get[1] = pat[p];
            tick();
            check_eq($sformatf("c1_go_hold%0d", p), o_go[1], 1);
        end
        tb_get[1] = 1'b1;
        n = 0;
        while (n < 20 && !o_done[1]) begin
            tick();
            n++;
        end
        tb_get[1] = 1'b0;
        check_eq("c1_done_seen", o_done[1], 1);
        check_eq("c1_tail_cycles", n, 1);
        tick();
        check_eq("c1_done_pulse", o_done[1], 0);

        // Starvation on client 2, then served.
        tb_len[11:8] = 4'd0;
        tb_valid[2] = 1'b1;
        exp_q[2].push_back(1);
        tick();
        tb_valid[2] = 1'b0;
        repeat (15) tick();
        check_eq("c2_starve_early", o_starve[2], 0);
        tick();
        check_eq("c2_starve_set", o_starve[2], 1);
        check_eq("c2_go_kept", o_go[2], 1);
        tb_get[2] = 1'b1;
        tick();
        tick();
        tb_get[2] = 1'b0;
        check_eq("c2_done", o_done[2], 1);
        tick();
        check_eq("c2_starve_sticky", o_starve[2], 1);
        check_eq("c2_spurious", o_spurious[2], 0);

        // Spurious grant on idle client 1.
        tb_get[1] = 1'b1;
        #1;
        check_eq("sp_no_beat", o_beat[1], 0);
        tick();
        tb_get[1] = 1'b0;
        check_eq("sp_flag", o_spurious[1], 1);
        check_eq("sp_idle", o_job_ready[1], 1);
        check_eq("sp_go", o_go[1], 0);
        check_eq("sp_other", o_spurious[0], 0);

        // Reset in the middle of a burst abandons it.
        tb_len[3:0] = 4'd7;
        tb_valid[0] = 1'b1;
        exp_q[0].push_back(8);
        tick();
        tb_valid[0] = 1'b0;
        tb_get[0] = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_go", o_go, 0);
        check_eq("rst_mid_ready", o_job_ready, 3'b111);
        check_eq("rst_mid_flags", {o_starve, o_spurious}, 0);
        tb_get = '0;
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            beat_cnt[i] = 0;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_eq("rst_mid_no_done", o_done, 0);

        // Closed loop with the arbiter model: three len=1 jobs per client.
        arb_mode = 1'b1;
        tb_len = {4'd1, 4'd1, 4'd1};
        for (int i = 0; i < N; i++) begin
            jobs_left[i] = 3;
            done_cnt[i] = 0;
        end
        n = 0;
        any_left = 1'b1;
        while (n < 400 && any_left) begin
            for (int i = 0; i < N; i++) begin
                tb_valid[i] = (jobs_left[i] > 0) && o_job_ready[i];
                if (tb_valid[i]) begin
                    exp_q[i].push_back(2);
                    jobs_left[i]--;
                end
            end
            tick();
            tb_valid = '0;
            n++;
            any_left = 1'b0;
            for (int i = 0; i < N; i++)
                if (jobs_left[i] > 0 || exp_q[i].size() != 0) any_left = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("loop_done_cnt[%0d]", i), done_cnt[i], 3);
            check_eq($sformatf("loop_pending[%0d]", i), exp_q[i].size(), 0);
        end
        check_eq("loop_spurious", o_spurious, 0);
        check_eq("loop_go_idle", o_go, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
